// File: rtl/axis_loopback_fifo_array.sv
// rtl/axis_loopback_fifo_array.sv - array of independent AXI-Stream FWFT FIFOs with fill level (optional AXIS_FIFO_PKT_MODE_EN store-and-forward)
module axis_loopback_fifo_array #(
    parameter int CH_NUM     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                         sys_clk,
    input  logic                         perif_rst,
    input  logic [CH_NUM-1:0]            s_axis_tvalid,
    output logic [CH_NUM-1:0]            s_axis_tready,
    input  logic [CH_NUM*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CH_NUM*DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [CH_NUM-1:0]            s_axis_tlast,
    output logic [CH_NUM-1:0]            m_axis_tvalid,
    input  logic [CH_NUM-1:0]            m_axis_tready,
    output logic [CH_NUM*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CH_NUM*DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [CH_NUM-1:0]            m_axis_tlast,
    output logic [CH_NUM*CNT_W-1:0]      fifo_cnt
`ifdef AXIS_FIFO_PKT_MODE_EN
    ,
    output logic [CH_NUM-1:0]            pkt_ovf
`endif
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int ENT_W  = DATA_WIDTH + KEEP_W + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [ENT_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             tready_r;
        logic             wr_en;
        logic             rd_en;
        logic             out_ok;
        logic [ENT_W-1:0] wr_entry;
        logic [ENT_W-1:0] rd_entry;

        assign wr_entry = {s_axis_tlast[c],
                           s_axis_tkeep[c*KEEP_W +: KEEP_W],
                           s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH]};
        assign rd_entry = mem[rd_ptr];

        assign wr_en = s_axis_tvalid[c] & tready_r;
        assign rd_en = m_axis_tvalid[c] & m_axis_tready[c];

`ifdef AXIS_FIFO_PKT_MODE_EN
        logic [CNT_W-1:0] pkt_cnt;
        logic             escape_r;
        logic             ovf_r;
        logic             escape_now;
        logic             acc_last;
        logic             ret_last;

        assign acc_last   = wr_en & s_axis_tlast[c];
        assign ret_last   = rd_en & rd_entry[ENT_W-1];
        // A full FIFO with no complete packet can never drain on its own; release it.
        assign escape_now = (cnt == CNT_FULL) && (pkt_cnt == '0);
        assign out_ok     = (pkt_cnt != '0) || escape_r || escape_now;
        assign pkt_ovf[c] = ovf_r;

        // Complete-packet count, cut-through escape latch and sticky overflow flag.
        always_ff @(posedge sys_clk) begin
            if (perif_rst) begin
                pkt_cnt  <= '0;
                escape_r <= 1'b0;
                ovf_r    <= 1'b0;
            end else begin
                if (acc_last && !ret_last) begin
                    pkt_cnt <= pkt_cnt + CNT_ONE;
                end else if (ret_last && !acc_last) begin
                    pkt_cnt <= pkt_cnt - CNT_ONE;
                end
                if (ret_last) begin
                    escape_r <= 1'b0;
                end else if (escape_now) begin
                    escape_r <= 1'b1;
                end
                if (escape_now) begin
                    ovf_r <= 1'b1;
                end
            end
        end
`else
        assign out_ok = 1'b1;
`endif

        // Occupancy after this cycle's write and read.
        always_comb begin
            cnt_nxt = cnt;
            if (wr_en && !rd_en) begin
                cnt_nxt = cnt + CNT_ONE;
            end else if (rd_en && !wr_en) begin
                cnt_nxt = cnt - CNT_ONE;
            end
        end

        // Pointers, count and registered ready; ready looks at the post-update count.
        always_ff @(posedge sys_clk) begin
            if (perif_rst) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
                tready_r <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                cnt      <= cnt_nxt;
                tready_r <= (cnt_nxt != CNT_FULL);
            end
        end

        // Storage write; contents need no reset since the pointers define validity.
        always_ff @(posedge sys_clk) begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_entry;
            end
        end

        assign s_axis_tready[c]                         = tready_r;
        assign m_axis_tvalid[c]                         = (cnt != '0) && out_ok;
        assign m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH] = rd_entry[DATA_WIDTH-1:0];
        assign m_axis_tkeep[c*KEEP_W +: KEEP_W]         = rd_entry[DATA_WIDTH +: KEEP_W];
        assign m_axis_tlast[c]                          = rd_entry[ENT_W-1];
        assign fifo_cnt[c*CNT_W +: CNT_W]               = cnt;
    end

endmodule

// File: tb/tb_axis_loopback_fifo_array.sv
// tb/tb_axis_loopback_fifo_array.sv - directed self-checking bench for axis_loopback_fifo_array
module tb_axis_loopback_fifo_array;

    logic         clk;
    logic         rst;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tready;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic [3:0]   s_tlast;
    logic [3:0]   m_tvalid;
    logic [3:0]   m_tready;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic [3:0]   m_tlast;
    logic [19:0]  fifo_cnt;
`ifdef AXIS_FIFO_PKT_MODE_EN
    logic [3:0]   pkt_ovf;
`endif

    int errors = 0;
    int checks = 0;

    axis_loopback_fifo_array #(.CH_NUM(4), .DATA_WIDTH(32), .DEPTH(16)) dut (
        .sys_clk       (clk),
        .perif_rst     (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .fifo_cnt      (fifo_cnt)
`ifdef AXIS_FIFO_PKT_MODE_EN
        ,
        .pkt_ovf       (pkt_ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (s_tready !== 4'h0) begin errors++; $display("FAIL rst_tready: got %h expected 0", s_tready); end
        checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL rst_tvalid: got %h expected 0", m_tvalid); end
        checks++; if (fifo_cnt !== 20'h0) begin errors++; $display("FAIL rst_cnt: got %h expected 0", fifo_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (s_tready !== 4'hF) begin errors++; $display("FAIL rst_release_tready: got %h expected f", s_tready); end
    endtask

    task automatic test_single;
        m_tready    = 4'h1;
        s_tvalid[0] = 1'b1;
        s_tdata[31:0] = 32'hA5A5_0001;
        s_tkeep[3:0]  = 4'hF;
        s_tlast[0]  = 1'b1;
        checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %b expected 0", m_tvalid[0]); end
        tick();
        s_tvalid[0] = 1'b0;
        checks++; if (m_tvalid[0] !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", m_tvalid[0]); end
        checks++; if (m_tdata[31:0] !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %h expected a5a50001", m_tdata[31:0]); end
        checks++; if ({m_tlast[0], m_tkeep[3:0]} !== 5'h1F) begin errors++; $display("FAIL single_last_keep: got %h expected 1f", {m_tlast[0], m_tkeep[3:0]}); end
        checks++; if (fifo_cnt[4:0] !== 5'd1) begin errors++; $display("FAIL single_cnt1: got %0d expected 1", fifo_cnt[4:0]); end
        tick();
        checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", m_tvalid[0]); end
        checks++; if (fifo_cnt[4:0] !== 5'd0) begin errors++; $display("FAIL single_cnt0: got %0d expected 0", fifo_cnt[4:0]); end
        m_tready = 4'h0;
    endtask

    task automatic test_full;
        for (int i = 0; i < 16; i++) begin
            checks++; if (s_tready[2] !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b expected 1", i, s_tready[2]); end
            s_tvalid[2]     = 1'b1;
            s_tdata[95:64]  = 32'(i);
            s_tkeep[11:8]   = 4'hF;
            s_tlast[2]      = 1'b1;
            tick();
        end
        s_tvalid[2] = 1'b0;
        checks++; if (s_tready[2] !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b expected 0", s_tready[2]); end
        checks++; if (fifo_cnt[14:10] !== 5'd16) begin errors++; $display("FAIL full_cnt16: got %0d expected 16", fifo_cnt[14:10]); end
        checks++; if (m_tdata[95:64] !== 32'd0) begin errors++; $display("FAIL full_head: got %h expected 0", m_tdata[95:64]); end
        m_tready[2] = 1'b1;
        tick();
        m_tready[2] = 1'b0;
        checks++; if (fifo_cnt[14:10] !== 5'd15) begin errors++; $display("FAIL full_cnt15: got %0d expected 15", fifo_cnt[14:10]); end
        checks++; if (s_tready[2] !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", s_tready[2]); end
        m_tready[2] = 1'b1;
        for (int i = 1; i < 16; i++) begin
            checks++; if ({m_tvalid[2], m_tdata[95:64]} !== {1'b1, 32'(i)}) begin errors++; $display("FAIL full_order_%0d: got %b/%h expected 1/%h", i, m_tvalid[2], m_tdata[95:64], i); end
            tick();
        end
        checks++; if (fifo_cnt[14:10] !== 5'd0) begin errors++; $display("FAIL full_cnt_end: got %0d expected 0", fifo_cnt[14:10]); end
        m_tready = 4'h0;
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 8; i++) begin
            s_tvalid[3]      = 1'b1;
            s_tdata[127:96]  = 32'(100 + i);
            s_tkeep[15:12]   = 4'h5;
            s_tlast[3]       = 1'b1;
            tick();
        end
        m_tready[3] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            s_tdata[127:96] = 32'(108 + k);
            checks++; if (m_tdata[127:96] !== 32'(100 + k)) begin errors++; $display("FAIL wrap_data_%0d: got %0d expected %0d", k, m_tdata[127:96], 100 + k); end
            checks++; if (fifo_cnt[19:15] !== 5'd8) begin errors++; $display("FAIL wrap_cnt_%0d: got %0d expected 8", k, fifo_cnt[19:15]); end
            tick();
        end
        s_tvalid[3] = 1'b0;
        checks++; if (m_tkeep[15:12] !== 4'h5) begin errors++; $display("FAIL wrap_keep: got %h expected 5", m_tkeep[15:12]); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (m_tdata[127:96] !== 32'(120 + k)) begin errors++; $display("FAIL wrap_drain_%0d: got %0d expected %0d", k, m_tdata[127:96], 120 + k); end
            tick();
        end
        checks++; if (fifo_cnt[19:15] !== 5'd0) begin errors++; $display("FAIL wrap_cnt_end: got %0d expected 0", fifo_cnt[19:15]); end
        m_tready = 4'h0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) begin
            s_tvalid[1]    = 1'b1;
            s_tdata[63:32] = 32'(200 + i);
            s_tlast[1]     = 1'b1;
            tick();
        end
        s_tvalid[1] = 1'b0;
        checks++; if (fifo_cnt[9:5] !== 5'd5) begin errors++; $display("FAIL mid_cnt5: got %0d expected 5", fifo_cnt[9:5]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fifo_cnt !== 20'h0) begin errors++; $display("FAIL mid_cnt0: got %h expected 0", fifo_cnt); end
        checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL mid_valid: got %h expected 0", m_tvalid); end
        m_tready = 4'hF;
        tick();
        checks++; if (s_tready !== 4'hF) begin errors++; $display("FAIL mid_ready: got %h expected f", s_tready); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL mid_stale_%0d: got %h expected 0", k, m_tvalid); end
            tick();
        end
        m_tready = 4'h0;
    endtask

    task automatic test_back_to_back;
        int sent [4];
        int rcvd [4];
        int maxc [4];
        int cyc;
        for (int c = 0; c < 4; c++) begin
            sent[c] = 0; rcvd[c] = 0; maxc[c] = 0;
        end
        cyc = 0;
        while (cyc < 3000 && !(rcvd[0] == 64 && rcvd[1] == 64 && rcvd[2] == 64 && rcvd[3] == 64)) begin
            for (int c = 0; c < 4; c++) begin
                s_tvalid[c]           = (sent[c] < 64);
                s_tdata[c*32 +: 32]   = 32'(c * 65536 + sent[c]);
                s_tkeep[c*4 +: 4]     = 4'hF;
                s_tlast[c]            = 1'b1;
                m_tready[c]           = 1'($urandom_range(0, 1));
            end
            for (int c = 0; c < 4; c++) begin
                if (int'(fifo_cnt[c*5 +: 5]) > maxc[c]) maxc[c] = int'(fifo_cnt[c*5 +: 5]);
                if (m_tvalid[c] && m_tready[c]) begin
                    checks++;
                    if (m_tdata[c*32 +: 32] !== 32'(c * 65536 + rcvd[c])) begin
                        errors++;
                        $display("FAIL stream_ch%0d_beat%0d: got %h expected %h", c, rcvd[c], m_tdata[c*32 +: 32], c * 65536 + rcvd[c]);
                    end
                    rcvd[c]++;
                end
                if (s_tvalid[c] && s_tready[c]) sent[c]++;
            end
            tick();
            cyc++;
        end
        s_tvalid = 4'h0;
        m_tready = 4'h0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (rcvd[c] != 64) begin errors++; $display("FAIL stream_count_ch%0d: got %0d expected 64", c, rcvd[c]); end
            checks++; if (maxc[c] > 16) begin errors++; $display("FAIL stream_maxcnt_ch%0d: got %0d expected <=16", c, maxc[c]); end
        end
        checks++; if (fifo_cnt !== 20'h0) begin errors++; $display("FAIL stream_cnt_end: got %h expected 0", fifo_cnt); end
    endtask

`ifdef AXIS_FIFO_PKT_MODE_EN
    task automatic test_pkt_mode;
        m_tready[0] = 1'b1;
        s_tkeep[3:0] = 4'hF;
        for (int i = 0; i < 3; i++) begin
            s_tvalid[0]   = 1'b1;
            s_tdata[31:0] = 32'(768 + i);
            s_tlast[0]    = (i == 2);
            if (i < 2) begin
                tick();
                checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL pkt_hold_%0d: got %b expected 0", i, m_tvalid[0]); end
            end else begin
                tick();
            end
        end
        s_tvalid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({m_tvalid[0], m_tlast[0], m_tdata[31:0]} !== {1'b1, 1'(i == 2), 32'(768 + i)}) begin errors++; $display("FAIL pkt_beat_%0d: got %b/%b/%h expected 1/%0d/%h", i, m_tvalid[0], m_tlast[0], m_tdata[31:0], i == 2, 768 + i); end
            tick();
        end
        checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL pkt_done: got %b expected 0", m_tvalid[0]); end
        m_tready[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tvalid[0]   = 1'b1;
            s_tdata[31:0] = 32'(1024 + i);
            s_tlast[0]    = 1'b0;
            tick();
        end
        s_tvalid[0] = 1'b0;
        checks++; if (m_tvalid[0] !== 1'b1) begin errors++; $display("FAIL pkt_escape_valid: got %b expected 1", m_tvalid[0]); end
        tick();
        checks++; if (pkt_ovf[0] !== 1'b1) begin errors++; $display("FAIL pkt_ovf_set: got %b expected 1", pkt_ovf[0]); end
        m_tready[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if ({m_tvalid[0], m_tdata[31:0]} !== {1'b1, 32'(1024 + i)}) begin errors++; $display("FAIL pkt_escape_%0d: got %b/%h expected 1/%h", i, m_tvalid[0], m_tdata[31:0], 1024 + i); end
            tick();
        end
        m_tready[0] = 1'b0;
        checks++; if (pkt_ovf[0] !== 1'b1) begin errors++; $display("FAIL pkt_ovf_sticky: got %b expected 1", pkt_ovf[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (pkt_ovf !== 4'h0) begin errors++; $display("FAIL pkt_ovf_clear: got %h expected 0", pkt_ovf); end
        tick();
    endtask
`endif

    initial begin
        rst      = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        m_tready = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef AXIS_FIFO_PKT_MODE_EN
        test_pkt_mode();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
